// File: rtl/a20_decode_scheduler.sv
// a20_decode_scheduler
// Time-shares one block_decode_a20 decoder between NUM_CH codeword sources.
// A round-robin arbiter picks a source. The scheduler sends the decoder a
// one-cycle code_length configuration pulse. It then steers exactly
// NUM_SYMBOLS soft symbols from that source into the decoder. The decoded
// bits go out on one AXI-Stream port, tagged with the source channel id.
// A codeword with an illegal code length is consumed and discarded.
//
// Ports:
//   clk, s_axis_aresetn             clock, synchronous active-low reset
//   req_code_length                 per-channel code length (8 bits each)
//   s_axis_tdata/tvalid/tlast/tready per-channel soft-symbol streams
//   dec_code_length(_valid)         decoder configuration
//   dec_s_axis_*                    symbol stream to the decoder
//   dec_m_axis_*                    decoded-bit stream from the decoder
//   m_axis_tdata/tuser/tvalid/tlast/tready  decoded bits with channel id
//   busy, err_len, err_frame        status and error pulses
module a20_decode_scheduler #(
    parameter  int NUM_CH       = 4,
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_SYMBOLS  = 20,
    parameter  int MAX_CODE_LEN = 13,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         s_axis_aresetn,
    input  logic [NUM_CH*8-1:0]          req_code_length,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [7:0]                   dec_code_length,
    output logic                         dec_code_length_valid,
    output logic [DATA_WIDTH-1:0]        dec_s_axis_tdata,
    output logic                         dec_s_axis_tvalid,
    output logic                         dec_s_axis_tlast,
    input  logic                         dec_s_axis_tready,
    input  logic                         dec_m_axis_tdata,
    input  logic                         dec_m_axis_tvalid,
    input  logic                         dec_m_axis_tlast,
    output logic                         dec_m_axis_tready,
    output logic                         m_axis_tdata,
    output logic [CH_W-1:0]              m_axis_tuser,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic                         err_len,
    output logic                         err_frame
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CH_W-1:0]   rr_ptr_r, grant_r, pick_s;
    logic [7:0]        len_r, pick_len_s, dec_code_length_r;
    logic [4:0]        sym_cnt_r;
    logic [3:0]        bit_cnt_r;
    logic              out_done_r, err_len_r, err_frame_r;
    logic              any_req_s, len_ok_s;
    logic              sel_tvalid_s, sel_tlast_s;
    logic [DATA_WIDTH-1:0] sel_tdata_s;
    logic              in_hs_s, out_active_s, out_hs_s, sym_last_s, bit_last_s;
    logic              unused_tlast_s;

    // Fold (ptr + offset) back into the channel range; inputs never exceed 2*NUM_CH-2.
    function automatic logic [CH_W-1:0] ch_wrap(input logic [CH_W:0] v);
        if (v >= (CH_W+1)'(NUM_CH)) begin
            return CH_W'(v - (CH_W+1)'(NUM_CH));
        end else begin
            return CH_W'(v);
        end
    endfunction

    assign unused_tlast_s = dec_m_axis_tlast;

    // Round-robin search: first valid channel at or after the pointer.
    always_comb begin
        any_req_s = 1'b0;
        pick_s    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any_req_s && s_axis_tvalid[ch_wrap({1'b0, rr_ptr_r} + (CH_W+1)'(i))]) begin
                any_req_s = 1'b1;
                pick_s    = ch_wrap({1'b0, rr_ptr_r} + (CH_W+1)'(i));
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    assign pick_len_s   = req_code_length[pick_s*8 +: 8];
    assign len_ok_s     = (pick_len_s >= 8'd1) && (pick_len_s <= 8'(MAX_CODE_LEN));
    assign sel_tvalid_s = s_axis_tvalid[grant_r];
    assign sel_tlast_s  = s_axis_tlast[grant_r];
    assign sel_tdata_s  = s_axis_tdata[grant_r*DATA_WIDTH +: DATA_WIDTH];

    // DROP accepts unconditionally; FEED waits for the decoder.
    assign in_hs_s      = sel_tvalid_s &&
                          (((state_r == ST_FEED) && dec_s_axis_tready) || (state_r == ST_DROP));
    // Once len bits are out, stop passing decoder output.
    assign out_active_s = ((state_r == ST_FEED) || (state_r == ST_DRAIN)) && !out_done_r;
    assign out_hs_s     = out_active_s && dec_m_axis_tvalid && m_axis_tready;
    assign sym_last_s   = (sym_cnt_r == 5'(NUM_SYMBOLS - 1));
    assign bit_last_s   = ({4'd0, bit_cnt_r} == (len_r - 8'd1));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = len_ok_s ? ST_CFG : ST_DROP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CFG:  state_s = ST_FEED;
            ST_FEED: begin
                if (in_hs_s && sym_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FEED;
                end
            end
            // out_done_r covers a decoder that finished early, while still in FEED.
            ST_DRAIN: begin
                if (out_done_r || (out_hs_s && bit_last_s)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DROP: begin
                if (in_hs_s && sym_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Upstream ready: only the granted channel, gated by the decoder in FEED.
    always_comb begin
        s_axis_tready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == grant_r) begin
                if (state_r == ST_FEED) begin
                    s_axis_tready[c] = dec_s_axis_tready;
                end else if (state_r == ST_DROP) begin
                    s_axis_tready[c] = 1'b1;
                end else begin
                    s_axis_tready[c] = 1'b0;
                end
            end else begin
                s_axis_tready[c] = 1'b0;
            end
        end
    end

    assign dec_code_length       = dec_code_length_r;
    assign dec_code_length_valid = (state_r == ST_CFG);
    assign dec_s_axis_tdata      = (state_r == ST_FEED) ? sel_tdata_s : '0;
    assign dec_s_axis_tvalid     = (state_r == ST_FEED) && sel_tvalid_s;
    assign dec_s_axis_tlast      = (state_r == ST_FEED) && sym_last_s;
    assign dec_m_axis_tready     = out_active_s && m_axis_tready;
    assign m_axis_tdata          = out_active_s && dec_m_axis_tdata;
    assign m_axis_tuser          = grant_r;
    assign m_axis_tvalid         = out_active_s && dec_m_axis_tvalid;
    assign m_axis_tlast          = out_active_s && bit_last_s;
    assign busy                  = (state_r != ST_IDLE);
    assign err_len               = err_len_r;
    assign err_frame             = err_frame_r;

    // State, grant bookkeeping, counters and error pulses.
    always_ff @(posedge clk) begin
        if (!s_axis_aresetn) begin
            state_r           <= ST_IDLE;
            rr_ptr_r          <= '0;
            grant_r           <= '0;
            len_r             <= 8'd0;
            dec_code_length_r <= 8'd0;
            sym_cnt_r         <= 5'd0;
            bit_cnt_r         <= 4'd0;
            out_done_r        <= 1'b0;
            err_len_r         <= 1'b0;
            err_frame_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            err_len_r   <= 1'b0;
            err_frame_r <= in_hs_s && (sel_tlast_s != sym_last_s);
            if ((state_r == ST_IDLE) && any_req_s) begin
                grant_r    <= pick_s;
                len_r      <= pick_len_s;
                rr_ptr_r   <= ch_wrap({1'b0, pick_s} + (CH_W+1)'(1));
                sym_cnt_r  <= 5'd0;
                bit_cnt_r  <= 4'd0;
                out_done_r <= 1'b0;
                err_len_r  <= !len_ok_s;
                if (len_ok_s) begin
                    dec_code_length_r <= pick_len_s;
                end
            end else begin
                if (in_hs_s) begin
                    sym_cnt_r <= sym_last_s ? 5'd0 : sym_cnt_r + 5'd1;
                end
                if (out_hs_s) begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_last_s) begin
                        out_done_r <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_a20_decode_scheduler.sv
// Scoreboard bench for a20_decode_scheduler. The bench also stands in for
// the decoder: each output bit k is the XOR-reduction of the k-th symbol the
// stand-in received. A reference model replays the arbitration over queued
// codewords and predicts the outputs.
module tb_a20_decode_scheduler;
    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int NSYM   = 20;
    localparam int MAXL   = 13;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   s_axis_aresetn;
    logic [NUM_CH*8-1:0]    req_code_length;
    logic [NUM_CH*DW-1:0]   s_axis_tdata;
    logic [NUM_CH-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [7:0]             dec_code_length;
    logic                   dec_code_length_valid;
    logic [DW-1:0]          dec_s_axis_tdata;
    logic                   dec_s_axis_tvalid, dec_s_axis_tlast, dec_s_axis_tready;
    logic                   dec_m_axis_tdata, dec_m_axis_tvalid, dec_m_axis_tlast, dec_m_axis_tready;
    logic                   m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [CH_W-1:0]        m_axis_tuser;
    logic                   busy, err_len, err_frame;

    a20_decode_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .NUM_SYMBOLS(NSYM), .MAX_CODE_LEN(MAXL)) dut (
        .clk(clk), .s_axis_aresetn(s_axis_aresetn), .req_code_length(req_code_length),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .dec_code_length(dec_code_length),
        .dec_code_length_valid(dec_code_length_valid), .dec_s_axis_tdata(dec_s_axis_tdata),
        .dec_s_axis_tvalid(dec_s_axis_tvalid), .dec_s_axis_tlast(dec_s_axis_tlast),
        .dec_s_axis_tready(dec_s_axis_tready), .dec_m_axis_tdata(dec_m_axis_tdata),
        .dec_m_axis_tvalid(dec_m_axis_tvalid), .dec_m_axis_tlast(dec_m_axis_tlast),
        .dec_m_axis_tready(dec_m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .err_len(err_len), .err_frame(err_frame)
    );

    typedef struct packed {
        logic [7:0]         len;
        logic               bad;
        logic [NSYM*DW-1:0] syms;
    } cw_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            bit_v;
        logic            last;
    } exp_t;

    cw_t        stage_q [NUM_CH][$];
    cw_t        src_q   [NUM_CH][$];
    int         src_idx [NUM_CH];
    exp_t       exp_q[$];
    logic [7:0] exp_len_q[$];
    logic [7:0] stub_syms[$];
    logic [1:0] stub_out_q[$];
    logic [7:0] stub_len;
    int checks = 0, errors = 0;
    int exp_err_len = 0, obs_err_len = 0, exp_err_frame = 0, obs_err_frame = 0;
    int model_ptr = 0;
    bit osc_mode = 1'b0;
    int osc_cnt = 0;
    bit chk_idle_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_cw(input int ch, input int len, input bit bad);
        cw_t cw;
        cw.len = 8'(len);
        cw.bad = bad;
        for (int i = 0; i < NSYM; i++) cw.syms[i*DW +: DW] = 8'($urandom);
        stage_q[ch].push_back(cw);
    endtask

    // Reference model: whenever the scheduler is free it serves the first
    // pending channel at or after the pointer; the pointer then moves past it.
    task automatic commit();
        int left = 0;
        int c;
        cw_t cw;
        for (int i = 0; i < NUM_CH; i++) left += stage_q[i].size();
        while (left > 0) begin
            c = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (c < 0 && stage_q[(model_ptr + i) % NUM_CH].size() > 0) c = (model_ptr + i) % NUM_CH;
            end
            cw = stage_q[c].pop_front();
            src_q[c].push_back(cw);
            model_ptr = (c + 1) % NUM_CH;
            left--;
            if (cw.bad) exp_err_frame++;
            if (cw.len >= 1 && cw.len <= MAXL) begin
                exp_len_q.push_back(cw.len);
                for (int k = 0; k < int'(cw.len); k++)
                    exp_q.push_back({CH_W'(c), ^cw.syms[k*DW +: DW], k == int'(cw.len) - 1});
            end else begin
                exp_err_len++;
            end
        end
    endtask

    task automatic wait_phase(input string name);
        int t = 0;
        bit empty;
        empty = 1'b0;
        while (t < 4000 && !(empty && exp_q.size() == 0 && exp_len_q.size() == 0 && busy == 1'b0)) begin
            @(negedge clk);
            t++;
            empty = 1'b1;
            for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() != 0) empty = 1'b0;
        end
        check({name, "_done"}, t < 4000, 1'b1);
        repeat (3) @(negedge clk);
        check({name, "_err_len"}, obs_err_len, exp_err_len);
        check({name, "_err_frame"}, obs_err_frame, exp_err_frame);
    endtask

    task automatic check_reset_zero(input string name);
        check(name, {s_axis_tready, dec_code_length, dec_code_length_valid, dec_s_axis_tdata,
                     dec_s_axis_tvalid, dec_s_axis_tlast, dec_m_axis_tready, m_axis_tdata,
                     m_axis_tuser, m_axis_tvalid, m_axis_tlast, busy, err_len, err_frame}, 64'd0);
    endtask

    // Driver: sources, decoder stand-in and output ready, updated after each edge.
    initial begin
        cw_t cw;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (src_q[c].size() > 0) begin
                    cw = src_q[c][0];
                    req_code_length[c*8 +: 8] = cw.len;
                    s_axis_tdata[c*DW +: DW]  = cw.syms[src_idx[c]*DW +: DW];
                    s_axis_tvalid[c] = (src_idx[c] == 0) || ($urandom_range(3) != 0);
                    s_axis_tlast[c]  = (src_idx[c] == NSYM - 1) || (cw.bad && src_idx[c] == NSYM - 2);
                end else begin
                    req_code_length[c*8 +: 8] = 8'($urandom);
                    s_axis_tdata[c*DW +: DW]  = 8'($urandom);
                    s_axis_tvalid[c] = 1'b0;
                    s_axis_tlast[c]  = 1'b0;
                end
            end
            dec_s_axis_tready = ($urandom_range(3) != 0);
            if (stub_out_q.size() > 0 && $urandom_range(3) != 0) begin
                dec_m_axis_tvalid = 1'b1;
                dec_m_axis_tdata  = stub_out_q[0][1];
                dec_m_axis_tlast  = stub_out_q[0][0];
            end else begin
                dec_m_axis_tvalid = 1'b0;
                dec_m_axis_tdata  = 1'b0;
                dec_m_axis_tlast  = 1'b0;
            end
            m_axis_tready = osc_mode ? ((osc_cnt % 30) >= 20) : ($urandom_range(9) < 7);
            osc_cnt++;
        end
    end

    // Monitor: observes handshakes mid-cycle and pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_axis_aresetn) begin
                check("tready_onehot0", $onehot0(s_axis_tready), 1'b1);
                if (chk_idle_next) begin
                    check("busy_after_last", busy, 1'b0);
                    chk_idle_next = 1'b0;
                end
                if (err_len) obs_err_len++;
                if (err_frame) obs_err_frame++;
                if (dec_code_length_valid) begin
                    check("cfg_expected", exp_len_q.size() > 0, 1'b1);
                    if (exp_len_q.size() > 0) check("cfg_len", dec_code_length, exp_len_q.pop_front());
                    stub_len = dec_code_length;
                    stub_syms.delete();
                end
                if (dec_s_axis_tvalid && dec_s_axis_tready) begin
                    check("dec_tlast_pos", dec_s_axis_tlast, stub_syms.size() == NSYM - 1);
                    stub_syms.push_back(dec_s_axis_tdata);
                    if (stub_syms.size() == NSYM) begin
                        for (int k = 0; k < int'(stub_len) && k < NSYM; k++)
                            stub_out_q.push_back({^stub_syms[k], k == int'(stub_len) - 1});
                        stub_syms.delete();
                    end
                end
                if (dec_m_axis_tvalid && dec_m_axis_tready && stub_out_q.size() > 0) void'(stub_out_q.pop_front());
                if (m_axis_tvalid && m_axis_tready) begin
                    check("out_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_ch", m_axis_tuser, e.ch);
                        check("out_bit", m_axis_tdata, e.bit_v);
                        check("out_last", m_axis_tlast, e.last);
                    end
                    if (m_axis_tlast) begin
                        check("busy_at_last", busy, 1'b1);
                        chk_idle_next = 1'b1;
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (s_axis_tvalid[c] && s_axis_tready[c] && src_q[c].size() > 0) begin
                        src_idx[c]++;
                        if (src_idx[c] == NSYM) begin
                            void'(src_q[c].pop_front());
                            src_idx[c] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int t;
        s_axis_aresetn = 1'b0;
        req_code_length = '0; s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        dec_s_axis_tready = 1'b0; dec_m_axis_tdata = 1'b0; dec_m_axis_tvalid = 1'b0;
        dec_m_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) src_idx[c] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_zero("reset_outputs");
        s_axis_aresetn = 1'b1;

        add_cw(0, 3, 1'b0); add_cw(2, 13, 1'b0); commit(); wait_phase("two_ch");
        add_cw(1, 5, 1'b0); commit(); wait_phase("ch1_len5");
        add_cw(3, 0, 1'b0); add_cw(3, 14, 1'b0); commit(); wait_phase("drop");
        for (int r = 0; r < 2; r++) for (int c = 0; c < NUM_CH; c++) add_cw(c, c + 1, 1'b0);
        commit(); wait_phase("all_ch");
        osc_mode = 1'b1; osc_cnt = 0;
        add_cw(0, 13, 1'b0); add_cw(1, 13, 1'b0); commit(); wait_phase("osc_ready");
        osc_mode = 1'b0;

        // Reset in the middle of a ch1 codeword.
        add_cw(1, 7, 1'b0); commit();
        t = 0;
        while (src_idx[1] < 10 && t < 2000) begin @(negedge clk); t++; end
        #1;
        check("mid_reset_reach", t < 2000, 1'b1);
        s_axis_aresetn = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin src_q[c].delete(); src_idx[c] = 0; end
        exp_q.delete(); exp_len_q.delete(); stub_syms.delete(); stub_out_q.delete();
        model_ptr = 0; chk_idle_next = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_zero("mid_reset_outputs");
        s_axis_aresetn = 1'b1;
        add_cw(2, 9, 1'b0); commit(); wait_phase("after_reset");

        add_cw(2, 6, 1'b1); commit(); wait_phase("bad_tlast");

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int j = 0; j < int'($urandom_range(2)); j++) begin
                    if ($urandom_range(9) == 0) add_cw(c, ($urandom_range(1) == 0) ? 0 : 14 + int'($urandom_range(1)), $urandom_range(3) == 0);
                    else add_cw(c, int'($urandom_range(MAXL, 1)), $urandom_range(3) == 0);
                end
            end
            add_cw(int'($urandom_range(NUM_CH - 1)), int'($urandom_range(MAXL, 1)), 1'b0);
            commit();
            wait_phase("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a20_decode_scheduler.md
Name: a20_decode_scheduler

Overview:
- Time-shares one block_decode_a20 instance between NUM_CH independent codeword sources.
- Arbitrates among sources round-robin, then issues the per-codeword code_length configuration pulse to the decoder.
- Steers exactly NUM_SYMBOLS soft symbols from the granted source into the decoder, and returns the decoded bits on a single AXI-Stream output tagged with the source channel id.
- Sits directly in front of the decoder, replacing the per-test code_length/stream driving.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 8, soft-symbol width.
- NUM_SYMBOLS, 20, symbols per codeword.
- MAX_CODE_LEN, 13, largest legal code length.
- CH_W, $clog2(NUM_CH), channel-id width (derived, not overridden).

Ports:
- clk  in  1  clock.
- s_axis_aresetn  in  1  synchronous active-low reset.
- req_code_length  in  NUM_CH*8  per-channel code length, sampled at grant.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  per-channel soft symbols.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel last; checked only, never forwarded.
- s_axis_tready  out  NUM_CH  per-channel ready.
- dec_code_length  out  8  to decoder code_length.
- dec_code_length_valid  out  1  to decoder code_length_valid.
- dec_s_axis_tdata  out  DATA_WIDTH  to decoder.
- dec_s_axis_tvalid  out  1  to decoder.
- dec_s_axis_tlast  out  1  to decoder.
- dec_s_axis_tready  in  1  from decoder.
- dec_m_axis_tdata  in  1  decoded bit from decoder.
- dec_m_axis_tvalid  in  1  from decoder.
- dec_m_axis_tlast  in  1  from decoder; ignored.
- dec_m_axis_tready  out  1  to decoder.
- m_axis_tdata  out  1  decoded bit.
- m_axis_tuser  out  CH_W  source channel id.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last decoded bit of the codeword.
- m_axis_tready  in  1  output ready.
- busy  out  1  high whenever the state is not IDLE.
- err_len  out  1  one-cycle pulse: illegal code length.
- err_frame  out  1  one-cycle pulse: upstream tlast mismatch.

Behaviour:

Reset (s_axis_aresetn=0 at a clk edge):
- State goes to IDLE; RR pointer goes to 0; counters clear.
- All outputs are 0: every tready, every valid, dec_code_length, busy, err_len, err_frame.
- Reset mid-codeword abandons the codeword: no tlast is emitted and no partial-result flush occurs. The decoder shares the same reset.

State machine IDLE -> CFG -> FEED -> DRAIN -> IDLE, plus DROP:
- IDLE:
  - If any s_axis_tvalid is set, grant the first valid channel at or after the RR pointer (wrapping).
  - Latch the grant g and len=req_code_length[g].
  - If 1<=len<=MAX_CODE_LEN, go to CFG; otherwise go to DROP.
  - The RR pointer becomes g+1 mod NUM_CH on every grant, including DROP grants.
- CFG (exactly 1 cycle):
  - dec_code_length=len, dec_code_length_valid=1, all tready=0.
  - Next state is FEED.
  - dec_code_length holds its value until the next CFG.
- FEED:
  - dec_s_axis_tdata/tvalid come from channel g combinationally.
  - s_axis_tready[g]=dec_s_axis_tready; every other tready=0.
  - sym_cnt increments on each dec handshake.
  - dec_s_axis_tlast=1 when sym_cnt==NUM_SYMBOLS-1; this is generated locally, not taken from upstream.
  - After the NUM_SYMBOLS-th handshake, go to DRAIN.
- Output path, active in both FEED and DRAIN:
  - m_axis_tdata=dec_m_axis_tdata, m_axis_tvalid=dec_m_axis_tvalid, dec_m_axis_tready=m_axis_tready, m_axis_tuser=g.
  - bit_cnt increments on each output handshake.
  - m_axis_tlast=1 when bit_cnt==len-1.
  - Outside FEED/DRAIN, m_axis_tvalid=0 and dec_m_axis_tready=0.
- DRAIN:
  - Stay until the len-th output handshake, then go to IDLE.
  - The next grant may occur in the cycle after that.
- DROP:
  - s_axis_tready[g]=1 and NUM_SYMBOLS symbols are consumed and discarded.
  - Decoder ports stay idle; no output is produced.
  - err_len pulses in the first DROP cycle.
  - After the NUM_SYMBOLS-th handshake, go to IDLE.

Latency and gaps:
- The request seen in IDLE at edge t gives dec_code_length_valid high during cycle t+1; the first symbol can pass in cycle t+2.
- Per-codeword scheduling overhead is 2 idle cycles (IDLE, CFG).

Framing:
- In FEED or DROP, err_frame pulses for 1 cycle after a handshake where s_axis_tlast[g] differs from (sym_cnt==NUM_SYMBOLS-1).
- The symbol is still accepted and the counting is unaffected.

Counter widths: sym_cnt is 5 bits; bit_cnt is 4 bits.

Test Plan:
1. Ch1 only, len=5, 20 symbols with tlast on #20 -> one dec_code_length_valid pulse carrying 5; exactly 20 symbols reach the decoder with dec tlast on #20; 5 output bits with tuser=1 and tlast on bit 5; err_frame=0.
2. Ch0 (len=3) and ch2 (len=13) valid simultaneously from reset -> ch0 served first, then ch2. Outputs are 3 bits tagged 0 followed by 13 bits tagged 2. ch2 tready stays 0 throughout ch0's service.
3. Ch3 with len=0, then ch3 with len=14 -> err_len pulses twice; 40 symbols consumed; dec_code_length_valid never rises; no m_axis_tvalid.
4. All 4 channels continuously valid, len=i+1 -> grants in order 0,1,2,3,0,1,... with pointer wrap.
5. m_axis_tready oscillating (20 low / 10 high) during 13-bit decodes -> no bit lost or duplicated; tlast only on bit 13; busy stays high until the last handshake.
6. Reset asserted after symbol 10 of ch1, then ch2 requests -> all outputs are 0 the cycle after the reset edge; ch2 is granted first with sym_cnt restarted; ch1 sends no tlast. Separately, upstream tlast asserted on symbol 19 -> single err_frame pulse and 20 symbols still forwarded.
